sccomp_run_ctl: RTL
===================

# sccomp_run_ctl

Run/debug controller for the single-cycle CPU (`sccomp`). It gates the CPU with a per-cycle clock enable and supports run, single-step and abort. It halts the CPU on a PC breakpoint, an executed-cycle limit or a misaligned PC. After every halt it scans out all 32 architectural registers through the CPU's `reg_sel`/`reg_data` debug port as a valid/ready stream, which replaces end-of-run register dumps done by hand.

## Interface
- `MAX_CYCLES`, default 1000: number of enabled CPU cycles after which a run halts with cause LIMIT.
- `CNT_W`, default 32: width of the cycle counter; `MAX_CYCLES` < 2^`CNT_W`.

Ports:
- `clk`  in  1  system clock; the CPU shares it.
- `rstn`  in  1  asynchronous active-low reset.
- `start`  in  1  1-cycle pulse: run from IDLE (clears the counter) or resume from HALT.
- `step`  in  1  1-cycle pulse: execute exactly one instruction from IDLE or HALT.
- `abort`  in  1  synchronous return to IDLE from any state.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  32  breakpoint PC.
- `cpu_pc`  in  32  current CPU PC.
- `cpu_en`  out  1  CPU clock enable; the CPU commits one instruction on each rising edge where this is 1.
- `reg_sel`  out  5  register-file debug read select.
- `reg_data`  in  32  register-file debug read data (combinational in `reg_sel`).
- `dump_valid`  out  1  dump word valid.
- `dump_ready`  in  1  dump consumer ready.
- `dump_data`  out  32  dump word; equals `reg_data`.
- `dump_idx`  out  5  register index of the current dump word.
- `dump_last`  out  1  high with the word for index 31.
- `halted`  out  1  controller is in HALT.
- `halt_cause`  out  2  00 STEP, 01 BREAK, 10 LIMIT, 11 ALIGN.
- `cycle_count`  out  `CNT_W`  enabled CPU cycles since the last start from IDLE.

## Operation
- States: IDLE, RUN, STEP, DUMP, HALT.
- **IDLE**
  - `start` → RUN and clears `cycle_count`.
  - `step` → STEP.
  - If both are asserted, `start` wins.
- **RUN**, halt condition evaluated each cycle with priority ALIGN (`cpu_pc[1:0]`≠0) > BREAK (`bp_en` && `cpu_pc`==`bp_addr`) > LIMIT (`cycle_count`==`MAX_CYCLES`).
  - Condition true: `cpu_en`=0 that cycle, `halt_cause` latched, next state DUMP. The instruction at the breakpoint is not executed.
  - Otherwise: `cpu_en`=1 and `cycle_count`+1.
  - `start` and `step` are ignored in RUN.
- **Resume skip:** the first RUN cycle after a resume from HALT ignores BREAK only, so resuming at the breakpoint PC makes progress. ALIGN and LIMIT are still checked on that cycle.
- **STEP:** one cycle with `cpu_en`=1 and `cycle_count`+1. No halt checks are made. Then DUMP with cause 00.
- **DUMP**
  - `reg_sel`=`dump_idx`, `dump_data`=`reg_data` (unregistered), `dump_valid`=1.
  - The CPU is frozen, so the data is stable while `dump_valid`&&!`dump_ready`.
  - On transfer (`dump_valid`&&`dump_ready`), `dump_idx`+1.
  - The transfer at index 31 (`dump_last`=1) → HALT and `dump_idx`→0.
  - Index 0 is dumped as delivered by the RF (0).
- **HALT:** `halted`=1; `halt_cause` and `cycle_count` are held.
  - `start` → RUN, resume; the counter is not cleared.
  - `step` → STEP.
  - If both are asserted, `start` wins.
- **Abort:** `abort` in any state → IDLE. `cpu_en` is forced to 0 in the same cycle (combinational gate). `dump_valid` drops next cycle, and a partial dump is discarded.
- The counter saturates at 2^`CNT_W`−1 and does not wrap.

## Timing
- **Reset values:** state IDLE, `cpu_en` 0, `reg_sel` 0, `dump_valid` 0, `dump_idx` 0, `dump_last` 0, `halted` 0, `halt_cause` 00, `cycle_count` 0. Reset is asynchronous and acts mid-run or mid-dump.
- `cpu_en` = (RUN && !halt_cond && !abort) || (STEP && !abort). It is combinational from state, `cpu_pc` and `bp_*`.
- **Start latency:** `start` sampled at edge N → `cpu_en`=1 during cycle N+1.
- **Halt latency:** the halt condition is visible during cycle N with `cpu_en`=0 → `dump_valid`=1 from cycle N+1.
- **Dump:** minimum 32 cycles with `dump_ready` tied high; `halted`=1 the cycle after the last transfer.
- **Step:** `step` at edge N → exactly one `cpu_en` cycle at N+1 → DUMP at N+2.
- All other outputs are registered.

## Test plan
- **Breakpoint:** bench PC model starts at 0, +4 per `cpu_en` cycle; `bp_en`=1, `bp_addr`=0x48, `start` pulse → exactly 18 `cpu_en` cycles.
  - `cycle_count`=18, `halt_cause`=01, PC stays 0x48.
  - 32 dump words with indices 0..31, `dump_last` only on 31, then `halted`=1.
- **Limit:** `bp_en`=0, `MAX_CYCLES`=1000 → 1000 enabled cycles, `halt_cause`=10, `cycle_count`=1000.
  - A following `start` re-halts after 0 enabled cycles.
- **Resume and step:** from the breakpoint halt at 0x48, `step` → one `cpu_en` pulse, PC 0x4C, `cycle_count`=19, cause 00, full dump.
  - `start` with `bp_addr`=0x4C → runs past 0x4C on the first cycle without re-halting there.
- **Backpressure:** `dump_ready` random at 50%, RF preloaded rN=0x1000+N → 32 transfers in index order.
  - `dump_data` is stable while stalled; each word matches its preload (index 0 → 0).
- **Misaligned PC:** PC model held at 0x00000042 → `start` gives 0 enabled cycles, cause 11, then dump.
- **Abort and reset:** `abort` at dump index 10 → IDLE next cycle, `dump_valid`=0, `dump_idx`=0.
  - `rstn` pulsed low mid-RUN → all outputs at reset values, `cpu_en`=0 immediately.

Source files
------------

// File: rtl/sccomp_run_ctl_if.sv
// Debug/run control bundle between the sccomp run controller and its
// environment: run commands, breakpoint setup, the CPU enable and PC, the
// register-file debug read port, the register dump stream and status.
interface sccomp_run_ctl_if #(
  parameter int CNT_W = 32
);
  // Run commands and breakpoint setup
  logic             start;
  logic             step;
  logic             abort;
  logic             bp_en;
  logic [31:0]      bp_addr;
  // CPU side
  logic [31:0]      cpu_pc;
  logic             cpu_en;
  logic [4:0]       reg_sel;
  logic [31:0]      reg_data;
  // Register dump stream
  logic             dump_valid;
  logic             dump_ready;
  logic [31:0]      dump_data;
  logic [4:0]       dump_idx;
  logic             dump_last;
  // Status
  logic             halted;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] cycle_count;

  // Controller side
  modport master (
    input  start, step, abort, bp_en, bp_addr, cpu_pc, reg_data, dump_ready,
    output cpu_en, reg_sel, dump_valid, dump_data, dump_idx, dump_last,
           halted, halt_cause, cycle_count
  );

  // Environment side (CPU, host, dump consumer)
  modport slave (
    output start, step, abort, bp_en, bp_addr, cpu_pc, reg_data, dump_ready,
    input  cpu_en, reg_sel, dump_valid, dump_data, dump_idx, dump_last,
           halted, halt_cause, cycle_count
  );
endinterface

// File: rtl/sccomp_run_ctl.sv
// Run/debug controller for the single-cycle CPU. Gates the CPU with a
// per-cycle enable, supports run / single-step / abort, halts on a PC
// breakpoint, a cycle limit or a misaligned PC, and after every halt
// streams all 32 architectural registers out through the RF debug port.
module sccomp_run_ctl #(
  parameter int unsigned MAX_CYCLES = 1000,
  parameter int          CNT_W      = 32
) (
  input  logic           clk,
  input  logic           rstn,
  sccomp_run_ctl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DUMP,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    C_STEP  = 2'b00,
    C_BREAK = 2'b01,
    C_LIMIT = 2'b10,
    C_ALIGN = 2'b11
  } cause_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES);

  state_t           r_state;
  cause_t           r_halt_cause;
  logic [CNT_W-1:0] r_cycle_count;
  logic [4:0]       r_dump_idx;
  logic             r_dump_valid;
  logic             r_dump_last;
  logic             r_halted;
  // Set for the first RUN cycle after a resume so a run restarted at the
  // breakpoint PC executes that instruction instead of re-halting on it.
  logic             r_resume;

  logic             w_align;
  logic             w_break;
  logic             w_limit;
  logic             w_halt;
  cause_t           w_cause;
  logic [CNT_W-1:0] w_count_inc;
  logic [4:0]       w_idx_next;

  // Halt condition for the current RUN cycle, with ALIGN > BREAK > LIMIT
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_cause = C_LIMIT;
    w_align = (bus.cpu_pc[1:0] != 2'b00);
    w_break = bus.bp_en && (bus.cpu_pc == bus.bp_addr) && !r_resume;
    w_limit = (r_cycle_count == LIMIT);
    w_halt  = w_align || w_break || w_limit;
    if (w_align) begin
      w_cause = C_ALIGN;
    end else if (w_break) begin
      w_cause = C_BREAK;
    end
  end

  // Counter saturates at all-ones instead of wrapping
  assign w_count_inc = (r_cycle_count == '1) ? r_cycle_count : r_cycle_count + 1'b1;
  assign w_idx_next  = r_dump_idx + 5'd1;

  // The enable is combinational so a halt or abort blocks the commit on
  // the very edge where it is seen.
  assign bus.cpu_en = !bus.abort &&
                      (((r_state == S_RUN) && !w_halt) || (r_state == S_STEP));

  assign bus.reg_sel     = r_dump_idx;
  assign bus.dump_data   = bus.reg_data;
  assign bus.dump_idx    = r_dump_idx;
  assign bus.dump_valid  = r_dump_valid;
  assign bus.dump_last   = r_dump_last;
  assign bus.halted      = r_halted;
  assign bus.halt_cause  = r_halt_cause;
  assign bus.cycle_count = r_cycle_count;

  // Controller FSM with all status outputs registered alongside the state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_halt_cause  <= C_STEP;
      r_cycle_count <= '0;
      r_dump_idx    <= '0;
      r_dump_valid  <= 1'b0;
      r_dump_last   <= 1'b0;
      r_halted      <= 1'b0;
      r_resume      <= 1'b0;
    end else if (bus.abort) begin
      // A partial dump is dropped; cause and count stay for inspection.
      r_state      <= S_IDLE;
      r_dump_idx   <= '0;
      r_dump_valid <= 1'b0;
      r_dump_last  <= 1'b0;
      r_halted     <= 1'b0;
      r_resume     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state       <= S_RUN;
            r_cycle_count <= '0;
            r_resume      <= 1'b0;
          end else if (bus.step) begin
            r_state <= S_STEP;
          end
        end
        S_RUN: begin
          r_resume <= 1'b0;
          if (w_halt) begin
            r_state      <= S_DUMP;
            r_halt_cause <= w_cause;
            r_dump_idx   <= '0;
            r_dump_valid <= 1'b1;
            r_dump_last  <= 1'b0;
          end else begin
            r_cycle_count <= w_count_inc;
          end
        end
        S_STEP: begin
          r_state       <= S_DUMP;
          r_cycle_count <= w_count_inc;
          r_halt_cause  <= C_STEP;
          r_dump_idx    <= '0;
          r_dump_valid  <= 1'b1;
          r_dump_last   <= 1'b0;
        end
        S_DUMP: begin
          if (bus.dump_ready) begin
            if (r_dump_last) begin
              r_state      <= S_HALT;
              r_dump_idx   <= '0;
              r_dump_valid <= 1'b0;
              r_dump_last  <= 1'b0;
              r_halted     <= 1'b1;
            end else begin
              r_dump_idx  <= w_idx_next;
              r_dump_last <= (w_idx_next == 5'd31);
            end
          end
        end
        S_HALT: begin
          if (bus.start) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
            r_resume <= 1'b1;
          end else if (bus.step) begin
            r_state  <= S_STEP;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
